// File: rtl/distortion_pipe_if.sv
// Sample/parameter bus for the pipelined stereo distortion stage.
// The master drives samples and per-sample parameters; the slave returns processed pairs.
interface distortion_pipe_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned GAIN_W = 16
);
   logic                     in_valid;
   logic signed [DATA_W-1:0] left_in;
   logic signed [DATA_W-1:0] right_in;
   logic        [GAIN_W-1:0] gain;
   logic        [DATA_W-1:0] threshold;
   logic        [1:0]        mode;
   logic                     out_valid;
   logic signed [DATA_W-1:0] left_out;
   logic signed [DATA_W-1:0] right_out;

   modport master (
      output in_valid, left_in, right_in, gain, threshold, mode,
      input  out_valid, left_out, right_out
   );

   modport slave (
      input  in_valid, left_in, right_in, gain, threshold, mode,
      output out_valid, left_out, right_out
   );
endinterface

// File: rtl/distortion_pipe.sv
// Pipelined stereo distortion: gain, then bypass / hard clip / soft clip, saturated to full scale.
// Fixed 3-cycle latency, one pair per cycle, with a saturating clip counter.
module distortion_pipe #(
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned GAIN_W    = 16,
   parameter int unsigned GAIN_FRAC = 7,
   parameter int unsigned CNT_W     = 16
) (
   input  logic               clk,
   input  logic               reset,
   distortion_pipe_if.slave   bus,
   input  logic               clip_clear,
   output logic [CNT_W-1:0]   clip_count
);

   localparam int unsigned PW = DATA_W + GAIN_W + 1;
   localparam logic signed [PW-1:0] SMAX = $signed((PW'(1) << (DATA_W - 1)) - PW'(1));
   localparam logic signed [PW-1:0] SMIN = ~SMAX;

   // Stage 1: scaled product plus everything the later stages need from this sample
   logic                     s1_valid;
   logic signed [PW-1:0]     s1_p_l, s1_p_r;
   logic signed [DATA_W-1:0] s1_raw_l, s1_raw_r;
   logic        [DATA_W-1:0] s1_thr;
   logic        [1:0]        s1_mode;

   logic signed [PW-1:0] gain_ext, prod_l, prod_r;

   assign gain_ext = $signed(PW'(bus.gain));
   assign prod_l   = PW'(bus.left_in)  * gain_ext;
   assign prod_r   = PW'(bus.right_in) * gain_ext;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_p_l   <= '0;
         s1_p_r   <= '0;
         s1_raw_l <= '0;
         s1_raw_r <= '0;
         s1_thr   <= '0;
         s1_mode  <= '0;
      end else begin
         s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            s1_p_l   <= prod_l >>> GAIN_FRAC;
            s1_p_r   <= prod_r >>> GAIN_FRAC;
            s1_raw_l <= bus.left_in;
            s1_raw_r <= bus.right_in;
            s1_thr   <= bus.threshold;
            s1_mode  <= bus.mode;
         end
      end
   end

   // Stage 2: shaping and saturation; mode 3 falls through to hard clip
   function automatic logic signed [DATA_W-1:0] shape(
      input logic signed [PW-1:0] p,
      input logic signed [PW-1:0] tc,
      input logic        [1:0]    m
   );
      logic signed [PW-1:0] mag;
      logic signed [PW-1:0] y;
      mag = p[PW-1] ? -p : p;
      y   = p;
      if (m == 2'd2) begin
         if (mag > tc) begin
            mag = tc + ((mag - tc) >>> 2);
            y   = p[PW-1] ? -mag : mag;
         end
      end else begin
         if (p > tc)       y = tc;
         else if (p < -tc) y = -tc;
      end
      if (y > SMAX)      y = SMAX;
      else if (y < SMIN) y = SMIN;
      return DATA_W'(y);
   endfunction

   logic signed [PW-1:0]     thr_ext, tc;
   logic signed [DATA_W-1:0] shp_l, shp_r;
   logic                     clip_c;

   always_comb begin
      thr_ext = $signed(PW'(s1_thr));
      tc      = (thr_ext > SMAX) ? SMAX : thr_ext;
      shp_l   = shape(s1_p_l, tc, s1_mode);
      shp_r   = shape(s1_p_r, tc, s1_mode);
      clip_c  = (s1_mode != 2'd0) &&
                ((PW'(shp_l) != s1_p_l) || (PW'(shp_r) != s1_p_r));
   end

   logic                     s2_valid;
   logic signed [DATA_W-1:0] s2_l, s2_r;
   logic                     s2_clip;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s2_valid <= 1'b0;
         s2_l     <= '0;
         s2_r     <= '0;
         s2_clip  <= 1'b0;
      end else begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_l    <= (s1_mode == 2'd0) ? s1_raw_l : shp_l;
            s2_r    <= (s1_mode == 2'd0) ? s1_raw_r : shp_r;
            s2_clip <= clip_c;
         end
      end
   end

   // Stage 3: output registers hold their value between pulses
   logic out_clip;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.out_valid <= 1'b0;
         bus.left_out  <= '0;
         bus.right_out <= '0;
         out_clip      <= 1'b0;
      end else begin
         bus.out_valid <= s2_valid;
         if (s2_valid) begin
            bus.left_out  <= s2_l;
            bus.right_out <= s2_r;
            out_clip      <= s2_clip;
         end
      end
   end

   // Counts on the cycle after each clipped out_valid, so a clear in that cycle wins
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clip_count <= '0;
      end else if (clip_clear) begin
         clip_count <= '0;
      end else if (bus.out_valid && out_clip && (clip_count != '1)) begin
         clip_count <= clip_count + CNT_W'(1);
      end
   end

endmodule
